// File: rtl/fe_pkg.sv
// rtl/fe_pkg.sv - shared types and constants for the fetch front end
package fe_pkg;

  typedef enum logic [0:0] {
    FETCH = 1'b0,
    FLUSH = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [15:0] instr;
  } fe_entry_s;

  localparam int unsigned INSTR_ALIGN = 2;

endpackage

// File: rtl/fe_fifo.sv
// rtl/fe_fifo.sv - circular instruction queue with push/pop/flush
module fe_fifo #(
  parameter int unsigned DEPTH_P = 4,
  parameter int unsigned WIDTH_P = 48,
  localparam int unsigned PTR_W = $clog2(DEPTH_P),
  localparam int unsigned CNT_W = $clog2(DEPTH_P + 1)
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               push_i,
  input  logic [WIDTH_P-1:0] data_i,
  input  logic               pop_i,
  input  logic               flush_i,
  output logic [WIDTH_P-1:0] data_o,
  output logic               full_o,
  output logic               empty_o,
  output logic [CNT_W-1:0]   count_o
);

  logic [WIDTH_P-1:0] mem_q [DEPTH_P];
  logic [PTR_W-1:0]   rd_ptr_q;
  logic [PTR_W-1:0]   wr_ptr_q;
  logic [CNT_W-1:0]   count_q;
  logic               do_push;
  logic               do_pop;

  // A full queue still accepts a push when the head leaves in the same cycle.
  assign do_pop  = pop_i && (count_q != '0);
  assign do_push = push_i && ((count_q != CNT_W'(DEPTH_P)) || do_pop);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      mem_q    <= '{default: '0};
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign full_o  = (count_q == CNT_W'(DEPTH_P));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

endmodule

// File: rtl/fe_fetch.sv
// rtl/fe_fetch.sv - in-order Thumb fetch stage feeding the microcode ROM
module fe_fetch
  import fe_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH_P   = 32,
  parameter int unsigned INSTR_WIDTH_P  = 16,
  parameter int unsigned OPCODE_WIDTH_P = 10,
  parameter int unsigned QUEUE_DEPTH_P  = 4,
  parameter logic [ADDR_WIDTH_P-1:0] RESET_PC_P = '0
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  output logic                      imem_req_v_o,
  output logic [ADDR_WIDTH_P-1:0]   imem_addr_o,
  input  logic                      imem_ready_i,
  input  logic                      imem_resp_v_i,
  input  logic [INSTR_WIDTH_P-1:0]  imem_data_i,
  input  logic                      redirect_v_i,
  input  logic [ADDR_WIDTH_P-1:0]   redirect_pc_i,
  output logic                      instr_v_o,
  input  logic                      instr_ready_i,
  output logic [INSTR_WIDTH_P-1:0]  instr_o,
  output logic [ADDR_WIDTH_P-1:0]   instr_pc_o,
  output logic [OPCODE_WIDTH_P-1:0] opcode_o
);

  localparam int unsigned CNT_W   = $clog2(QUEUE_DEPTH_P + 1);
  localparam int unsigned ENTRY_W = ADDR_WIDTH_P + INSTR_WIDTH_P;

  fetch_state_e            state_q, state_d;
  logic [ADDR_WIDTH_P-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_WIDTH_P-1:0] resp_pc_q, resp_pc_d;
  logic [ADDR_WIDTH_P-1:0] redirect_tgt;
  logic [CNT_W-1:0]        outstanding_q, outstanding_d;
  logic [CNT_W-1:0]        stale_q, stale_d;
  logic [CNT_W-1:0]        q_count;
  logic [CNT_W:0]          credit_sum;
  logic                    req_v, accept, resp_ok, push, pop;
  logic                    q_empty, q_full;
  logic [ENTRY_W-1:0]      head;

  assign redirect_tgt = redirect_pc_i & ~ADDR_WIDTH_P'(1);

  // Queued plus in-flight entries bound the requests, so the queue never overflows.
  assign credit_sum = {1'b0, q_count} + {1'b0, outstanding_q};
  assign req_v      = !reset_i && (state_q == FETCH) &&
                      (credit_sum < (CNT_W + 1)'(QUEUE_DEPTH_P));
  assign accept     = req_v && imem_ready_i;
  assign resp_ok    = imem_resp_v_i && (outstanding_q != '0);
  assign push       = resp_ok && (stale_q == '0) && !redirect_v_i;
  assign pop        = !q_empty && instr_ready_i;

  always_comb begin
    outstanding_d = outstanding_q + CNT_W'(accept) - CNT_W'(resp_ok);
    stale_d       = stale_q;
    fetch_pc_d    = fetch_pc_q;
    resp_pc_d     = resp_pc_q;
    state_d       = state_q;

    if (accept) fetch_pc_d = fetch_pc_q + ADDR_WIDTH_P'(INSTR_ALIGN);
    if (push) resp_pc_d = resp_pc_q + ADDR_WIDTH_P'(INSTR_ALIGN);
    if (resp_ok && (stale_q != '0)) stale_d = stale_q - CNT_W'(1);

    // Everything still in flight after this cycle belongs to the old path.
    if (redirect_v_i) begin
      fetch_pc_d = redirect_tgt;
      resp_pc_d  = redirect_tgt;
      stale_d    = outstanding_d;
    end

    unique case (state_q)
      FETCH:   if (redirect_v_i && (stale_d != '0)) state_d = FLUSH;
      FLUSH:   if (stale_d == '0) state_d = FETCH;
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q       <= FETCH;
      fetch_pc_q    <= RESET_PC_P;
      resp_pc_q     <= RESET_PC_P;
      outstanding_q <= '0;
      stale_q       <= '0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      resp_pc_q     <= resp_pc_d;
      outstanding_q <= outstanding_d;
      stale_q       <= stale_d;
    end
  end

  fe_fifo #(
    .DEPTH_P(QUEUE_DEPTH_P),
    .WIDTH_P(ENTRY_W)
  ) u_queue (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .push_i (push),
    .data_i ({resp_pc_q, imem_data_i}),
    .pop_i  (pop),
    .flush_i(redirect_v_i),
    .data_o (head),
    .full_o (q_full),
    .empty_o(q_empty),
    .count_o(q_count)
  );

  assign imem_req_v_o = req_v;
  assign imem_addr_o  = fetch_pc_q;
  assign instr_v_o    = !q_empty;
  assign instr_pc_o   = head[ENTRY_W-1:INSTR_WIDTH_P];
  assign instr_o      = head[INSTR_WIDTH_P-1:0];
  assign opcode_o     = instr_o[INSTR_WIDTH_P-1 -: OPCODE_WIDTH_P];

  a_resp_has_owner: assert property (@(posedge clk_i) disable iff (reset_i)
    imem_resp_v_i |-> (outstanding_q != '0));
  a_no_overflow: assert property (@(posedge clk_i) disable iff (reset_i)
    !(push && q_full && !pop));

endmodule
